arb_req_fifo: RTL and testbench

- Per-requestor ingress buffer that sits directly upstream of the round-robin arbiter.
- Absorbs bursty requests from one source.
- Presents a first-word-fall-through valid/data pair to one arbiter input (A or B).
- One instance per arbiter input. Decouples source timing from arbitration, so a request that loses arbitration is held rather than dropped.

---
 rtl/arb_pkg.sv | 13 +
 rtl/arb_req_fifo_if.sv | 31 +++
 rtl/arb_fifo_mem.sv | 23 ++
 rtl/arb_req_fifo.sv | 81 ++++++++
 tb/tb_arb_req_fifo.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter and its per-input request FIFOs.
package arb_pkg;

    localparam int ARB_DATA_WIDTH = 16;

    // Arbiter input indices; one arb_req_fifo instance feeds each.
    localparam int ARB_IDX_A = 0;
    localparam int ARB_IDX_B = 1;
    localparam int ARB_NUM_IN = 2;

    typedef logic [ARB_DATA_WIDTH-1:0] arb_data_t;

endpackage

// File: rtl/arb_req_fifo_if.sv
// Source-side and arbiter-side handshake bundle for one arb_req_fifo instance.
interface arb_req_fifo_if
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = ARB_DATA_WIDTH,
    parameter int DEPTH      = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic                  wvalid_i;
    logic                  wready_o;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  rvalid_o;
    logic                  rready_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic [PTR_W:0]        count_o;
    logic                  ovf_o;

    // FIFO side.
    modport slave (
        input  wvalid_i, wdata_i, rready_i,
        output wready_o, rvalid_o, rdata_o, count_o, ovf_o
    );

    // Source/arbiter side.
    modport master (
        output wvalid_i, wdata_i, rready_i,
        input  wready_o, rvalid_o, rdata_o, count_o, ovf_o
    );

endinterface

// File: rtl/arb_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one async read port, no reset.
module arb_fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  aclk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

    always_ff @(posedge aclk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/arb_req_fifo.sv
// Per-requestor FWFT ingress buffer in front of one arbiter input; holds requests that lose arbitration.
module arb_req_fifo
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = ARB_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          areset,
    arb_req_fifo_if.slave fif
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic [PTR_W:0]        count_next;
    logic                  ovf;
    logic                  full;
    logic                  not_empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;

    // Status is decoded from registered count only, so no input reaches an output combinationally.
    assign full      = (count == DEPTH_C);
    assign not_empty = (count != '0);

    assign push = fif.wvalid_i & ~full;
    assign pop  = fif.rready_i & not_empty;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers are PTR_W bits wide with DEPTH a power of two, so wrap is free.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                      ovf <= 1'b0;
        else if (fif.wvalid_i && full)   ovf <= 1'b1;
    end

    arb_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .aclk  (aclk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (fif.wdata_i),
        .raddr (rd_ptr),
        .rdata (head_data)
    );

    // Empty forces zero so stale or uninitialised storage never reaches the arbiter.
    assign fif.rdata_o  = not_empty ? head_data : '0;
    assign fif.rvalid_o = not_empty;
    assign fif.wready_o = ~full;
    assign fif.count_o  = count;
    assign fif.ovf_o    = ovf;

endmodule

// File: tb/tb_arb_req_fifo.sv
// Directed self-checking bench for arb_req_fifo (DEPTH=4, DATA_WIDTH=16).
module tb_arb_req_fifo;

    logic aclk;
    logic areset;
    int   checks;
    int   failures;

    arb_req_fifo_if #(.DATA_WIDTH(16), .DEPTH(4)) fif ();

    arb_req_fifo #(.DATA_WIDTH(16), .DEPTH(4)) u_dut (
        .aclk   (aclk),
        .areset (areset),
        .fif    (fif)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        aclk = 0; areset = 1;
        fif.wvalid_i = 0; fif.wdata_i = '0; fif.rready_i = 0;

        // 1. reset
        repeat (3) @(posedge aclk);
        #1 areset = 0;
        chk("rst_count",  32'(fif.count_o),  0);
        chk("rst_rvalid", 32'(fif.rvalid_o), 0);
        chk("rst_wready", 32'(fif.wready_o), 1);
        chk("rst_rdata",  32'(fif.rdata_o),  0);
        chk("rst_ovf",    32'(fif.ovf_o),    0);

        // rready on an empty buffer is ignored
        fif.rready_i = 1; tick();
        chk("empty_pop_count", 32'(fif.count_o), 0);
        fif.rready_i = 0;

        // 2. single push, then pop
        fif.wvalid_i = 1; fif.wdata_i = 16'hA5A5; tick();
        fif.wvalid_i = 0;
        chk("single_rvalid", 32'(fif.rvalid_o), 1);
        chk("single_rdata",  32'(fif.rdata_o),  32'hA5A5);
        chk("single_count",  32'(fif.count_o),  1);
        fif.rready_i = 1; tick(); fif.rready_i = 0;
        chk("pop_rvalid", 32'(fif.rvalid_o), 0);
        chk("pop_rdata",  32'(fif.rdata_o),  0);

        // push and pop together while empty: only the push happens
        fif.wvalid_i = 1; fif.rready_i = 1; fif.wdata_i = 16'h0042; tick();
        fif.wvalid_i = 0;
        chk("empty_pushpop_count", 32'(fif.count_o), 1);
        chk("empty_pushpop_rdata", 32'(fif.rdata_o), 32'h0042);
        tick(); fif.rready_i = 0;
        chk("empty_pushpop_drain", 32'(fif.count_o), 0);

        // 3. fill, overflow, full push+pop, drain
        for (int i = 1; i <= 4; i++) begin
            fif.wvalid_i = 1; fif.wdata_i = 16'(i); tick();
        end
        fif.wvalid_i = 0;
        chk("full_wready", 32'(fif.wready_o), 0);
        chk("full_count",  32'(fif.count_o),  4);
        chk("full_ovf0",   32'(fif.ovf_o),    0);
        fif.wvalid_i = 1; fif.wdata_i = 16'd5; tick();
        fif.wvalid_i = 0;
        chk("ovf_set",   32'(fif.ovf_o),   1);
        chk("ovf_count", 32'(fif.count_o), 4);
        chk("ovf_head",  32'(fif.rdata_o), 1);
        // full: push blocked, pop alone completes
        fif.wvalid_i = 1; fif.wdata_i = 16'd6; fif.rready_i = 1; tick();
        fif.wvalid_i = 0;
        chk("full_pushpop_count", 32'(fif.count_o), 3);
        for (int i = 2; i <= 4; i++) begin
            chk("drain_data", 32'(fif.rdata_o), 32'(i));
            tick();
        end
        fif.rready_i = 0;
        chk("drain_count", 32'(fif.count_o), 0);
        chk("ovf_sticky",  32'(fif.ovf_o),   1);

        // 4. continuous streaming across pointer wrap
        fif.wvalid_i = 1; fif.rready_i = 1;
        for (int k = 0; k < 10; k++) begin
            fif.wdata_i = 16'(16'h0100 + k); tick();
            chk("stream_count", 32'(fif.count_o), 1);
            chk("stream_data",  32'(fif.rdata_o), 32'(16'h0100 + k));
        end
        fif.wvalid_i = 0; tick(); fif.rready_i = 0;
        chk("stream_end_count", 32'(fif.count_o), 0);

        // 5. simultaneous push and pop at count 2
        fif.wvalid_i = 1; fif.wdata_i = 16'h0020; tick();
        fif.wdata_i = 16'h0021; tick();
        chk("pp_pre_count", 32'(fif.count_o), 2);
        fif.wdata_i = 16'h0022; fif.rready_i = 1; tick();
        fif.wvalid_i = 0;
        chk("pp_count", 32'(fif.count_o), 2);
        chk("pp_head",  32'(fif.rdata_o), 32'h0021);
        tick();
        chk("pp_tail",  32'(fif.rdata_o), 32'h0022);
        tick(); fif.rready_i = 0;
        chk("pp_end_count", 32'(fif.count_o), 0);

        // 6. async reset between edges with count 3
        for (int i = 0; i < 3; i++) begin
            fif.wvalid_i = 1; fif.wdata_i = 16'(16'h0031 + i); tick();
        end
        fif.wvalid_i = 0;
        chk("pre_rst_count", 32'(fif.count_o), 3);
        #2 areset = 1;
        #1;
        chk("arst_count",  32'(fif.count_o),  0);
        chk("arst_rvalid", 32'(fif.rvalid_o), 0);
        chk("arst_wready", 32'(fif.wready_o), 1);
        chk("arst_rdata",  32'(fif.rdata_o),  0);
        chk("arst_ovf",    32'(fif.ovf_o),    0);
        #1 areset = 0;
        fif.wvalid_i = 1; fif.wdata_i = 16'h7777; tick();
        fif.wvalid_i = 0;
        chk("post_rst_data",  32'(fif.rdata_o), 32'h7777);
        chk("post_rst_count", 32'(fif.count_o), 1);
        chk("post_rst_mem0",  32'(u_dut.u_mem.mem[0]), 32'h7777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
